instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Packs field-level instruction descriptions (kind, rd, rs1, rs2, func3, alt, imm) into 32-bit RV32I machine words for the subset the control unit decodes: R-ALU, I-ALU, LOAD, STORE, BRANCH.
- Buffers encoded words in a FIFO and streams them into instruction memory at sequential word addresses.
- Used by the bench and boot loader to fill instruction RAM without precompiled hex.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- ADDR_WIDTH, 32, width of mem_addr
- BASE_ADDR, 32'h0, byte address of the first word written after reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- in_kind  input  3  0=R-ALU, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH; 5-7 illegal
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_func3  input  3  func3 field
- in_alt  input  1  sets instr[30] for R-ALU (sub/sra); ignored for other kinds
- in_imm  input  13  signed immediate; I/LOAD/STORE use [11:0]; BRANCH uses [12:1], and [0] must be 0
- mem_we  output  1  word valid for memory
- mem_ready  input  1  memory accepts the word this cycle
- mem_addr  output  ADDR_WIDTH  byte address of the current word
- mem_wdata  output  32  encoded instruction
- words_written  output  16  count of completed memory writes; wraps
- err  output  1  sticky: an illegal bundle was dropped

Behaviour:
- Reset:
  - FIFO empty; mem_we=0; mem_wdata=0.
  - mem_addr=BASE_ADDR; words_written=0; err=0.
  - in_ready=1 in the cycle after reset deasserts.
- Accept (handshake):
  - A bundle is accepted when in_valid & in_ready.
  - in_ready = (FIFO count < DEPTH); it depends only on registered state, never on in_valid.
- Encoding (combinational at push, then written into the FIFO):
  - R: {alt?7'b0100000:7'b0, rs2, rs1, func3, rd, 7'b0110011}
  - I: {imm[11:0], rs1, func3, rd, 7'b0010011}
  - LOAD: as I with opcode 7'b0000011
  - STORE: {imm[11:5], rs2, rs1, func3, imm[4:0], 7'b0100011}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], 7'b1100011}
- Output side:
  - mem_we = FIFO non-empty; mem_wdata = FIFO head.
  - Pop when mem_we & mem_ready. On pop: mem_addr += 4 (wraps modulo 2^ADDR_WIDTH); words_written += 1.
- Latency: a bundle accepted in cycle N into an empty FIFO gives mem_we=1 with its word in cycle N+1.
- Back-pressure: while mem_ready=0, mem_we, mem_addr and mem_wdata hold stable.
- Full: in_ready=0 and no push-through. A pop in the same cycle frees a slot for cycle N+1 only.
- Push and pop in the same cycle (non-empty, not full): count unchanged, order preserved.
- Reset mid-stream: buffered words are discarded and the address restarts at BASE_ADDR.

Optional Feature:
ENC_CHECK_EN
- Defined: illegal kind (5-7), or BRANCH with in_imm[0]=1, is still accepted (in_ready unchanged) but nothing is pushed, and err is set until rst.
- Not defined: no checks and err is tied to 0. Illegal kinds encode as I-ALU; BRANCH silently drops imm[0].

Test Plan:
- R add, rd=3 rs1=1 rs2=2 f3=0 alt=0 -> mem_wdata=0x002081B3 at mem_addr=0x0, mem_we one cycle after accept; with alt=1 -> 0x402081B3 at 0x4.
- I addi, rd=1 rs1=0 imm=-1 -> 0xFFF00093; STORE sw, rs1=1 rs2=2 f3=2 imm=4 -> 0x0020A223.
- BRANCH bne, rs1=1 rs2=2 f3=1 imm=-8 -> 0xFE209CE3.
- Fill: hold mem_ready=0 and offer 5 bundles with DEPTH=4 -> in_ready=0 after 4 accepts and mem_wdata stable; release mem_ready -> 4 writes at 0x0,0x4,0x8,0xC, then the 5th at 0x10; words_written=5.
- With ENC_CHECK_EN, kind=6 -> accepted, no mem_we, err=1; BRANCH imm=3 -> dropped, err stays 1; rst -> err=0, mem_addr=BASE_ADDR.
- Reset with 3 buffered words -> mem_we=0 next cycle; a new bundle writes to BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder with an output FIFO that streams words into instruction memory.
// Optional build macro ENC_CHECK_EN drops illegal bundles and raises a sticky err flag.
module instr_encoder #(
    parameter int unsigned           DEPTH      = 4,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_kind,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_func3,
    input  logic                  in_alt,
    input  logic [12:0]           in_imm,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [15:0]           words_written,
    output logic                  err
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [31:0]           fifo_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           words_q;
    logic [31:0]           enc_word;
    logic                  legal, accept, push, pop;

    always_comb begin
        // Kinds 5-7 fall through to the I-ALU encoding.
        enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, 7'b0010011};
        case (in_kind)
            3'd0: enc_word = {(in_alt ? 7'b0100000 : 7'b0000000), in_rs2, in_rs1, in_func3,
                              in_rd, 7'b0110011};
            3'd2: enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, 7'b0000011};
            3'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], 7'b0100011};
            3'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3, in_imm[4:1],
                              in_imm[11], 7'b1100011};
            default: ;
        endcase
    end

`ifdef ENC_CHECK_EN
    logic err_q;

    assign legal = (in_kind <= 3'd4) && !((in_kind == 3'd4) && in_imm[0]);
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && !legal) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_imm0;

    assign legal       = 1'b1;
    assign err         = 1'b0;
    assign unused_imm0 = in_imm[0];
`endif

    assign in_ready      = (count_q < CntW'(DEPTH));
    assign accept        = in_valid && in_ready;
    assign push          = accept && legal;
    assign mem_we        = (count_q != '0);
    assign pop           = mem_we && mem_ready;
    assign mem_addr      = addr_q;
    assign words_written = words_q;
    assign mem_wdata     = mem_we ? fifo_q[rd_ptr_q] : 32'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            words_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                addr_q   <= addr_q + ADDR_WIDTH'(4);
                words_q  <= words_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: ;
            endcase
        end
    end

endmodule
